// File: rtl/usb_tx_bit_sched.sv
// USB TX bit scheduler: sequences SYNC, LSB-first payload bytes and EOP,
// generating bit timing and inserting a stuffed zero after six consecutive ones.
module usb_tx_bit_sched #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       line_bit,
    output logic       se0,
    output logic       bit_tick,
    output logic       stuff_active,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      ones_cnt_q, ones_cnt_d;
    logic            last_q, last_d;
    logic            eob_q, eob_d;
    logic            byte_ready_q, byte_ready_d;
    logic            line_bit_q, line_bit_d;
    logic            se0_q, se0_d;
    logic            bit_tick_q, bit_tick_d;
    logic            stuff_active_q, stuff_active_d;
    logic            tx_active_q, tx_active_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_error_q, tx_error_d;

    logic boundary_c;
    logic stuff_due_c;
    logic byte_end_c;
    logic fetch_due_c;
    logic do_fetch_c;
    logic do_eop_c;

    always_comb begin
        state_d        = state_q;
        cyc_cnt_d      = cyc_cnt_q;
        shreg_d        = shreg_q;
        bit_idx_d      = bit_idx_q;
        ones_cnt_d     = ones_cnt_q;
        last_d         = last_q;
        eob_d          = eob_q;
        line_bit_d     = line_bit_q;
        se0_d          = se0_q;
        stuff_active_d = stuff_active_q;
        tx_active_d    = tx_active_q;
        tx_done_d      = 1'b0;
        tx_error_d     = 1'b0;
        do_fetch_c     = 1'b0;
        do_eop_c       = 1'b0;

        boundary_c  = (cyc_cnt_q == CW'(CLKS_PER_BIT - 1));
        stuff_due_c = (ones_cnt_q == 3'd5) && line_bit_q;
        byte_end_c  = (bit_idx_q == 3'd7);
        // A fetch happens at this period's boundary (SYNC always has last_q == 0)
        fetch_due_c = !last_q &&
                      ((((state_q == S_SYNC) || (state_q == S_DATA)) && byte_end_c && !stuff_due_c) ||
                       ((state_q == S_STUFF) && eob_q));

        if (state_q == S_IDLE || boundary_c) begin
            cyc_cnt_d = '0;
        end else begin
            cyc_cnt_d = cyc_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d        = S_SYNC;
                    shreg_d        = SYNC_BYTE;
                    bit_idx_d      = 3'd0;
                    ones_cnt_d     = 3'd0;
                    last_d         = 1'b0;
                    eob_d          = 1'b0;
                    tx_active_d    = 1'b1;
                    line_bit_d     = SYNC_BYTE[0];
                    se0_d          = 1'b0;
                    stuff_active_d = 1'b0;
                end
            end
            S_SYNC, S_DATA: begin
                if (boundary_c) begin
                    shreg_d    = {1'b0, shreg_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    ones_cnt_d = line_bit_q ? ones_cnt_q + 3'd1 : 3'd0;
                    if (stuff_due_c) begin
                        state_d        = S_STUFF;
                        ones_cnt_d     = 3'd0;
                        eob_d          = byte_end_c;
                        line_bit_d     = 1'b0;
                        stuff_active_d = 1'b1;
                    end else if (byte_end_c) begin
                        do_fetch_c = !last_q;
                        do_eop_c   = last_q;
                    end else begin
                        line_bit_d = shreg_q[1];
                    end
                end
            end
            S_STUFF: begin
                if (boundary_c) begin
                    stuff_active_d = 1'b0;
                    if (eob_q) begin
                        do_fetch_c = !last_q;
                        do_eop_c   = last_q;
                    end else begin
                        state_d    = S_DATA;
                        line_bit_d = shreg_q[0];
                    end
                end
            end
            S_EOP_SE0: begin
                if (boundary_c) begin
                    if (bit_idx_q == 3'd0) begin
                        bit_idx_d = 3'd1;
                    end else begin
                        state_d    = S_EOP_J;
                        se0_d      = 1'b0;
                        line_bit_d = 1'b1;
                    end
                end
            end
            S_EOP_J: begin
                if (boundary_c) begin
                    state_d     = S_IDLE;
                    tx_active_d = 1'b0;
                    line_bit_d  = 1'b0;
                    ones_cnt_d  = 3'd0;
                    tx_done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Fetch resolves against the strobe raised for this boundary
        if (do_fetch_c) begin
            if (byte_valid) begin
                state_d    = S_DATA;
                shreg_d    = byte_data;
                last_d     = byte_last;
                bit_idx_d  = 3'd0;
                line_bit_d = byte_data[0];
            end else begin
                tx_error_d = 1'b1;
                do_eop_c   = 1'b1;
            end
        end

        if (do_eop_c) begin
            state_d        = S_EOP_SE0;
            bit_idx_d      = 3'd0;
            se0_d          = 1'b1;
            line_bit_d     = 1'b0;
            stuff_active_d = 1'b0;
        end

        // Raised one cycle early so the registered strobe lands on the boundary
        byte_ready_d = fetch_due_c && (cyc_cnt_q == CW'(CLKS_PER_BIT - 2));
        bit_tick_d   = tx_active_d && (cyc_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cyc_cnt_q      <= '0;
            shreg_q        <= 8'h00;
            bit_idx_q      <= 3'd0;
            ones_cnt_q     <= 3'd0;
            last_q         <= 1'b0;
            eob_q          <= 1'b0;
            byte_ready_q   <= 1'b0;
            line_bit_q     <= 1'b0;
            se0_q          <= 1'b0;
            bit_tick_q     <= 1'b0;
            stuff_active_q <= 1'b0;
            tx_active_q    <= 1'b0;
            tx_done_q      <= 1'b0;
            tx_error_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cyc_cnt_q      <= cyc_cnt_d;
            shreg_q        <= shreg_d;
            bit_idx_q      <= bit_idx_d;
            ones_cnt_q     <= ones_cnt_d;
            last_q         <= last_d;
            eob_q          <= eob_d;
            byte_ready_q   <= byte_ready_d;
            line_bit_q     <= line_bit_d;
            se0_q          <= se0_d;
            bit_tick_q     <= bit_tick_d;
            stuff_active_q <= stuff_active_d;
            tx_active_q    <= tx_active_d;
            tx_done_q      <= tx_done_d;
            tx_error_q     <= tx_error_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign line_bit     = line_bit_q;
    assign se0          = se0_q;
    assign bit_tick     = bit_tick_q;
    assign stuff_active = stuff_active_q;
    assign tx_active    = tx_active_q;
    assign tx_done      = tx_done_q;
    assign tx_error     = tx_error_q;

endmodule

// File: tb/tb_usb_tx_bit_sched.sv
// Directed bench for usb_tx_bit_sched: records one packet per run as per-period
// bit vectors and compares them with hand-derived sequences.
module tb_usb_tx_bit_sched;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       line_bit;
    logic       se0;
    logic       bit_tick;
    logic       stuff_active;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [4];
    int n_bytes;
    int idx;

    logic [31:0] o_line, o_se0, o_stuff;
    int o_per, o_done, o_br, o_brcyc, o_scyc, o_err, o_errcyc;

    usb_tx_bit_sched #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'h80)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .line_bit(line_bit), .se0(se0),
        .bit_tick(bit_tick), .stuff_active(stuff_active), .tx_active(tx_active),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        byte_valid = (idx < n_bytes);
        byte_data  = (idx < n_bytes) ? mem[idx] : 8'h00;
        byte_last  = (idx == n_bytes - 1);
    endtask

    function automatic logic [31:0] outs();
        return 32'({byte_ready, line_bit, se0, bit_tick, stuff_active, tx_active, tx_done, tx_error});
    endfunction

    // Cycle k=1 is the first cycle after the tx_start edge
    task automatic run_pkt(input int inject);
        int   k;
        logic done;
        logic consume;
        idx = 0;
        drive_src();
        o_line = '0; o_se0 = '0; o_stuff = '0;
        o_per = 0; o_done = 0; o_br = 0; o_brcyc = 0; o_scyc = 0; o_err = 0; o_errcyc = 0;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        k = 1;
        done = 1'b0;
        while (!done && k < 400) begin
            if (k == 1) chk("first_cycle", 32'({tx_active, bit_tick, se0}), 32'h6);
            if (bit_tick) begin
                if (o_per < 32) begin
                    o_line[o_per]  = line_bit;
                    o_se0[o_per]   = se0;
                    o_stuff[o_per] = stuff_active;
                end
                o_per++;
            end
            if (stuff_active) o_scyc++;
            if (byte_ready) begin o_br++; o_brcyc = k; end
            if (tx_error) begin o_err++; o_errcyc = k; end
            if (tx_done) begin o_done = k; done = 1'b1; end
            consume  = byte_ready && byte_valid;
            tx_start = (k == inject);
            if (!done) begin
                @(posedge clk); #1;
                k++;
                tx_start = 1'b0;
                if (consume) begin
                    idx++;
                    drive_src();
                end
            end
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_pkt(input string t, input logic [31:0] line, input logic [31:0] s0,
                             input logic [31:0] st, input int per, input int done_cyc,
                             input int br, input int brcyc, input int scyc, input int err);
        chk({t, "_line"},  o_line, line);
        chk({t, "_se0"},   o_se0, s0);
        chk({t, "_stuff"}, o_stuff, st);
        chk({t, "_per"},   32'(o_per), 32'(per));
        chk({t, "_done"},  32'(o_done), 32'(done_cyc));
        chk({t, "_br"},    32'(o_br), 32'(br));
        chk({t, "_brcyc"}, 32'(o_brcyc), 32'(brcyc));
        chk({t, "_scyc"},  32'(o_scyc), 32'(scyc));
        chk({t, "_err"},   32'(o_err), 32'(err));
    endtask

    initial begin
        int cnt;
        rst = 1'b1; tx_start = 1'b0; byte_data = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
        n_bytes = 0; idx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", outs(), 32'h0);

        // single 0x00, last
        mem[0] = 8'h00; n_bytes = 1;
        run_pkt(0);
        check_pkt("b00", 32'h0004_0080, 32'h0003_0000, 32'h0, 19, 77, 1, 32, 0, 0);

        // single 0xFF: stuff after fifth data bit
        mem[0] = 8'hFF; n_bytes = 1;
        run_pkt(0);
        check_pkt("bff", 32'h0009_DF80, 32'h0006_0000, 32'h0000_2000, 20, 81, 1, 32, 4, 0);

        // single 0xFC: stuff lands after the last payload bit, before EOP
        mem[0] = 8'hFC; n_bytes = 1;
        run_pkt(0);
        check_pkt("bfc", 32'h0008_FC80, 32'h0006_0000, 32'h0001_0000, 20, 81, 1, 32, 4, 0);

        // 0xFC then 0x01: second fetch strobe on the STUFF boundary
        mem[0] = 8'hFC; mem[1] = 8'h01; n_bytes = 2;
        run_pkt(0);
        check_pkt("fc01", 32'h0802_FC80, 32'h0600_0000, 32'h0001_0000, 28, 113, 2, 68, 4, 0);

        // 0xE0 then 0x07: run of ones spans the byte boundary
        mem[0] = 8'hE0; mem[1] = 8'h07; n_bytes = 2;
        run_pkt(0);
        check_pkt("e007", 32'h0807_E080, 32'h0600_0000, 32'h0008_0000, 28, 113, 2, 64, 4, 0);

        // underrun right after SYNC
        n_bytes = 0;
        run_pkt(0);
        check_pkt("undr", 32'h0000_0480, 32'h0000_0300, 32'h0, 11, 45, 1, 32, 0, 1);
        chk("undr_errcyc", 32'(o_errcyc), 32'd33);

        // stray tx_start mid-packet leaves the packet unchanged
        mem[0] = 8'h00; n_bytes = 1;
        run_pkt(20);
        check_pkt("inj", 32'h0004_0080, 32'h0003_0000, 32'h0, 19, 77, 1, 32, 0, 0);

        // reset during byte 0 bit 3 (period 11 spans cycles 45..48)
        mem[0] = 8'h00; n_bytes = 1; idx = 0; drive_src();
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        chk("pre_rst_active", 32'(tx_active), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_outs", outs(), 32'h0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tx_done || tx_active) cnt++;
        end
        chk("rst_no_done", 32'(cnt), 32'd0);

        // recovery after reset
        mem[0] = 8'hFF; n_bytes = 1;
        run_pkt(0);
        check_pkt("post", 32'h0009_DF80, 32'h0006_0000, 32'h0000_2000, 20, 81, 1, 32, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
